// File: rtl/state_snapshot_engine.sv
// Captures the register file and a data-memory window on a trigger or a periodic
// timer, and streams the snapshot as tagged records over a valid/ready port.
module state_snapshot_engine #(
    parameter int XLEN           = 64,
    parameter int REG_CNT        = 32,
    parameter int REG_IDX_W      = 5,
    parameter int ADDR_W         = 16,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_trigger,
    input  logic                 i_period_en,
    input  logic [31:0]          i_period,
    input  logic [ADDR_W-1:0]    i_mem_start,
    input  logic [ADDR_W-1:0]    i_mem_end,
    output logic [REG_IDX_W-1:0] o_reg_idx,
    input  logic [XLEN-1:0]      i_reg_data,
    output logic                 o_mem_rd_en,
    output logic [ADDR_W-1:0]    o_mem_addr,
    input  logic [XLEN-1:0]      i_mem_rd_data,
    output logic                 o_rec_valid,
    input  logic                 i_rec_ready,
    output logic [1:0]           o_rec_tag,
    output logic [ADDR_W-1:0]    o_rec_index,
    output logic [XLEN-1:0]      o_rec_data,
    output logic                 o_busy,
    output logic [15:0]          o_dump_count,
    output logic                 o_overrun
);

    localparam int                    STEP     = XLEN / 8;
    localparam logic [ADDR_W-1:0]     REG_LAST = ADDR_W'(REG_CNT - 1);
    localparam logic [2:0]            RD_LAT   = 3'(MEM_RD_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_REGS     = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_MEM_OUT  = 3'd5,
        ST_TRAILER  = 3'd6
    } state_t;

    state_t                state_r, state_s;
    logic [XLEN-1:0]       cyc_r;
    logic [31:0]           per_cnt_r;
    logic                  fire_s, start_s, xfer_s;
    logic [ADDR_W:0]       next_addr_s;

    logic [ADDR_W-1:0]     start_r, start_s_nxt, end_r, end_s;
    logic [ADDR_W-1:0]     addr_r, addr_s, mem_cnt_r, mem_cnt_s;
    logic [2:0]            wait_r, wait_s;
    logic [REG_IDX_W-1:0]  reg_idx_r, reg_idx_s;
    logic                  mem_rd_en_r, mem_rd_en_s;
    logic [ADDR_W-1:0]     mem_addr_r, mem_addr_s;
    logic                  rec_valid_r, rec_valid_s;
    logic [1:0]            rec_tag_r, rec_tag_s;
    logic [ADDR_W-1:0]     rec_index_r, rec_index_s;
    logic [XLEN-1:0]       rec_data_r, rec_data_s;
    logic                  busy_r, busy_s;
    logic [15:0]           dump_count_r, dump_count_s;
    logic                  overrun_r, overrun_s;

    assign fire_s      = i_period_en && (i_period != 32'd0) && (per_cnt_r == i_period - 32'd1);
    assign start_s     = i_trigger | fire_s;
    assign xfer_s      = rec_valid_r & i_rec_ready;
    assign next_addr_s = {1'b0, addr_r} + (ADDR_W + 1)'(STEP);

    // Free-running timestamp counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_r <= '0;
        end else begin
            cyc_r <= cyc_r + XLEN'(1);
        end
    end

    // Periodic trigger counter; idles at zero while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt_r <= 32'd0;
        end else if (!i_period_en || (i_period == 32'd0) || fire_s) begin
            per_cnt_r <= 32'd0;
        end else begin
            per_cnt_r <= per_cnt_r + 32'd1;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_s      = state_r;
        start_s_nxt  = start_r;
        end_s        = end_r;
        addr_s       = addr_r;
        mem_cnt_s    = mem_cnt_r;
        wait_s       = wait_r;
        reg_idx_s    = reg_idx_r;
        mem_rd_en_s  = mem_rd_en_r;
        mem_addr_s   = mem_addr_r;
        rec_valid_s  = rec_valid_r;
        rec_tag_s    = rec_tag_r;
        rec_index_s  = rec_index_r;
        rec_data_s   = rec_data_r;
        busy_s       = busy_r;
        dump_count_s = dump_count_r;
        overrun_s    = overrun_r | (start_s & (state_r != ST_IDLE));
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s     = ST_HEADER;
                    start_s_nxt = i_mem_start;
                    end_s       = i_mem_end;
                    addr_s      = i_mem_start;
                    mem_cnt_s   = '0;
                    reg_idx_s   = '0;
                    busy_s      = 1'b1;
                    rec_valid_s = 1'b1;
                    rec_tag_s   = 2'd0;
                    rec_index_s = '0;
                    rec_data_s  = cyc_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // o_reg_idx always points at the next register to load, so one record per cycle is possible.
            ST_HEADER, ST_REGS: begin
                if (xfer_s && (state_r == ST_REGS) && (rec_index_r == REG_LAST)) begin
                    if (start_r < end_r) begin
                        state_s     = ST_MEM_REQ;
                        rec_valid_s = 1'b0;
                        mem_rd_en_s = 1'b1;
                        mem_addr_s  = addr_r;
                    end else begin
                        state_s     = ST_TRAILER;
                        rec_tag_s   = 2'd3;
                        rec_index_s = mem_cnt_r;
                        rec_data_s  = cyc_r;
                    end
                end else if (xfer_s) begin
                    state_s     = ST_REGS;
                    rec_tag_s   = 2'd1;
                    rec_index_s = ADDR_W'(reg_idx_r);
                    rec_data_s  = i_reg_data;
                    reg_idx_s   = reg_idx_r + REG_IDX_W'(1);
                end else begin
                    state_s = state_r;
                end
            end
            ST_MEM_REQ: begin
                mem_rd_en_s = 1'b0;
                wait_s      = 3'd1;
                state_s     = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (wait_r == RD_LAT) begin
                    state_s     = ST_MEM_OUT;
                    rec_valid_s = 1'b1;
                    rec_tag_s   = 2'd2;
                    rec_index_s = addr_r;
                    rec_data_s  = i_mem_rd_data;
                    mem_cnt_s   = mem_cnt_r + ADDR_W'(1);
                end else begin
                    wait_s = wait_r + 3'd1;
                end
            end
            // A step that leaves the address space ends the window even if end is not reached.
            ST_MEM_OUT: begin
                if (xfer_s && (next_addr_s[ADDR_W] || (next_addr_s[ADDR_W-1:0] >= end_r))) begin
                    state_s     = ST_TRAILER;
                    rec_tag_s   = 2'd3;
                    rec_index_s = mem_cnt_r;
                    rec_data_s  = cyc_r;
                end else if (xfer_s) begin
                    state_s     = ST_MEM_REQ;
                    addr_s      = next_addr_s[ADDR_W-1:0];
                    rec_valid_s = 1'b0;
                    mem_rd_en_s = 1'b1;
                    mem_addr_s  = next_addr_s[ADDR_W-1:0];
                end else begin
                    state_s = ST_MEM_OUT;
                end
            end
            ST_TRAILER: begin
                if (xfer_s) begin
                    state_s      = ST_IDLE;
                    rec_valid_s  = 1'b0;
                    busy_s       = 1'b0;
                    dump_count_s = dump_count_r + 16'd1;
                end else begin
                    state_s = ST_TRAILER;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rec_valid_s = 1'b0;
                mem_rd_en_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any dump in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            start_r      <= '0;
            end_r        <= '0;
            addr_r       <= '0;
            mem_cnt_r    <= '0;
            wait_r       <= 3'd0;
            reg_idx_r    <= '0;
            mem_rd_en_r  <= 1'b0;
            mem_addr_r   <= '0;
            rec_valid_r  <= 1'b0;
            rec_tag_r    <= 2'd0;
            rec_index_r  <= '0;
            rec_data_r   <= '0;
            busy_r       <= 1'b0;
            dump_count_r <= 16'd0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            start_r      <= start_s_nxt;
            end_r        <= end_s;
            addr_r       <= addr_s;
            mem_cnt_r    <= mem_cnt_s;
            wait_r       <= wait_s;
            reg_idx_r    <= reg_idx_s;
            mem_rd_en_r  <= mem_rd_en_s;
            mem_addr_r   <= mem_addr_s;
            rec_valid_r  <= rec_valid_s;
            rec_tag_r    <= rec_tag_s;
            rec_index_r  <= rec_index_s;
            rec_data_r   <= rec_data_s;
            busy_r       <= busy_s;
            dump_count_r <= dump_count_s;
            overrun_r    <= overrun_s;
        end
    end

    assign o_reg_idx    = reg_idx_r;
    assign o_mem_rd_en  = mem_rd_en_r;
    assign o_mem_addr   = mem_addr_r;
    assign o_rec_valid  = rec_valid_r;
    assign o_rec_tag    = rec_tag_r;
    assign o_rec_index  = rec_index_r;
    assign o_rec_data   = rec_data_r;
    assign o_busy       = busy_r;
    assign o_dump_count = dump_count_r;
    assign o_overrun    = overrun_r;

endmodule

// File: doc/state_snapshot_engine.md
Name: state_snapshot_engine

Overview:
Synthesizable successor to the simulation-only register/CSR/memory dump flow. On a trigger pulse or a programmable periodic timer, it captures a snapshot of the core register file and a configurable data-memory window. The snapshot is streamed out as tagged records over a valid/ready port toward a debug UART/trace sink. It sits beside the core in the SoC top and uses a spare register-file read port and a data-RAM read port.

Parameters:
XLEN, 64, data width of register and memory words (32 or 64)
REG_CNT, 32, number of register-file entries dumped
REG_IDX_W, 5, width of register index (clog2 REG_CNT)
ADDR_W, 16, byte-address width of memory window
MEM_RD_LATENCY, 1, cycles from o_mem_rd_en to valid i_mem_rd_data (1..4)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_trigger  in  1  single-cycle dump request
i_period_en  in  1  enables periodic triggering
i_period  in  32  period in cycles; 0 = periodic disabled
i_mem_start  in  ADDR_W  window start byte address (inclusive)
i_mem_end  in  ADDR_W  window end byte address (exclusive)
o_reg_idx  out  REG_IDX_W  register-file read index
i_reg_data  in  XLEN  combinational read data for o_reg_idx
o_mem_rd_en  out  1  memory read strobe
o_mem_addr  out  ADDR_W  memory read byte address
i_mem_rd_data  in  XLEN  memory read data, MEM_RD_LATENCY after strobe
o_rec_valid  out  1  record valid
i_rec_ready  in  1  sink accepts record
o_rec_tag  out  2  0=HEADER 1=REG 2=MEM 3=TRAILER
o_rec_index  out  ADDR_W  reg index (zero-extended) or byte address
o_rec_data  out  XLEN  record payload
o_busy  out  1  dump in progress
o_dump_count  out  16  completed dumps, wraps
o_overrun  out  1  sticky: trigger lost while busy

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE; all outputs 0; cycle counter, period counter, dump count and overrun cleared. Reset mid-dump aborts immediately; no trailer is emitted.
- Cycle counter: XLEN-bit, free-running from reset release, wraps.
- Period counter: counts while i_period_en=1 and i_period!=0. At i_period-1 it generates an internal fire and reloads to 0. Deasserting i_period_en clears it.
- Start condition: i_trigger OR fire, taken only in IDLE. Simultaneous trigger and fire produce one dump. A start condition while o_busy=1 sets o_overrun, which stays set until reset; the request is dropped.
- On start: i_mem_start/i_mem_end latched; o_busy=1 from the next cycle until the trailer is accepted.
- FSM: IDLE -> HEADER -> REGS -> MEM_REQ -> MEM_WAIT -> MEM_OUT -> (MEM_REQ | TRAILER) -> IDLE.
- HEADER: tag 0, index 0, data = cycle counter at start.
- REGS: REG_CNT records in order 0..REG_CNT-1, tag 1, data = i_reg_data sampled into the output register. o_reg_idx advances only on acceptance.
- MEM: step = XLEN/8. addr = start, then start+step, … while addr < end. Each word is one read: o_mem_rd_en pulses 1 cycle in MEM_REQ, data is captured after MEM_RD_LATENCY, then emitted in MEM_OUT (tag 2, index = addr). Only one read is outstanding at a time.
- Window rules: end<=start gives no MEM records. A partial last word is still read and emitted. If addr+step overflows ADDR_W, the current word is the last.
- TRAILER: tag 3, index = number of MEM records, data = cycle counter. Acceptance increments o_dump_count and returns to IDLE.
- Handshake: a record transfers on o_rec_valid && i_rec_ready. While valid && !ready, tag/index/data stay stable. Valid never drops without a transfer except on reset. Back-to-back records are allowed: 1 record/cycle in HEADER/REGS with ready held high.
- Latency: i_trigger cycle N gives HEADER valid at cycle N+1.

Test Plan:
- Reset, XLEN=64, trigger at cycle 10, ready=1, window 0x7FEC..0x8000 -> HEADER data=10, 32 REG records idx 0..31, 3 MEM records at 0x7FEC/0x7FF4/0x7FFC, TRAILER index=3, dump_count=1.
- Random ready (50% duty) over the same dump -> identical record sequence; fields stable while stalled; no drops or duplicates.
- i_period=500, i_period_en=1 for 2000 cycles, ready=1 -> 4 dumps; HEADER timestamps differ by 500; overrun=0.
- Trigger while busy, with ready=0 during REGS -> overrun=1 (sticky), dump_count still increments by 1 only.
- Window start=0x100, end=0x100 -> no MEM records; TRAILER index=0. Window start=0xFFF8, end=0xFFFF, ADDR_W=16 -> exactly one MEM record at 0xFFF8.
- i_rst_n low during the MEM phase -> valid/busy drop to 0 asynchronously; the next trigger restarts cleanly with dump_count=0.
